// File: rtl/custom_leds_pkg.sv
// Shared types and constants for the custom LED sequencer/arbiter.
package custom_leds_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_ROTATE = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    SRC_STATIC = 2'd0,
    SRC_SEQ    = 2'd1,
    SRC_BUTTON = 2'd2
  } src_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_VALUE  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_STEPS  = 3'd4;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_OVR_BIT  = 3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef struct packed {
    logic [7:0] pattern;
    logic       dir;
  } step_t;

  // One sequencer step. A bounce pattern touching both edges cannot move,
  // so it holds while DIR still flips (keeps 0xFF at 0xFF).
  function automatic step_t seq_step(input mode_e mode, input logic [7:0] pat,
                                     input logic dir);
    step_t res;
    res.pattern = pat;
    res.dir     = dir;
    case (mode)
      MODE_BLINK:  res.pattern = ~pat;
      MODE_ROTATE: res.pattern = {pat[6:0], pat[7]};
      MODE_BOUNCE: begin
        if (dir == DIR_LEFT) begin
          if (pat[7]) begin
            res.dir     = DIR_RIGHT;
            res.pattern = pat[0] ? pat : {1'b0, pat[7:1]};
          end else begin
            res.pattern = {pat[6:0], 1'b0};
          end
        end else begin
          if (pat[0]) begin
            res.dir     = DIR_LEFT;
            res.pattern = pat[7] ? pat : {pat[6:0], 1'b0};
          end else begin
            res.pattern = {1'b0, pat[7:1]};
          end
        end
      end
      default: res.pattern = pat;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/custom_leds_if.sv
// Avalon-MM slave bus bundle for the LED controller register file.
interface custom_leds_if;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/custom_leds_debounce.sv
// Button conditioner: 2-FF synchronizer followed by a stability counter.
module custom_leds_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button_n,
  output logic pressed
);

  localparam logic [31:0] CNT_LAST =
    (DEBOUNCE_CYCLES == 0) ? 32'd0 : 32'(DEBOUNCE_CYCLES - 1);

  logic [1:0]  r_sync;
  logic [31:0] r_cnt;
  logic        r_pressed;
  logic        w_sync_pressed;

  assign w_sync_pressed = ~r_sync[1];
  assign pressed        = r_pressed;

  // Synchronise the raw button; released (high) out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], button_n};
    end
  end

  // Accept a new level only after it differs for DEBOUNCE_CYCLES edges in a row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= 32'd0;
      r_pressed <= 1'b0;
    end else if (w_sync_pressed != r_pressed) begin
      if (r_cnt >= CNT_LAST) begin
        r_pressed <= w_sync_pressed;
        r_cnt     <= 32'd0;
      end else begin
        r_cnt <= r_cnt + 32'd1;
      end
    end else begin
      r_cnt <= 32'd0;
    end
  end

endmodule

// File: rtl/custom_leds_ctrl.sv
// LED bank controller: register file, pattern sequencer FSM and output arbiter.
module custom_leds_ctrl
  import custom_leds_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned DEFAULT_PERIOD  = 12_500_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic            clk,
  input  logic            reset_n,
  custom_leds_if.slave    avs,
  input  logic [1:0]      button_n,
  input  logic [3:0]      dipsw,
  output logic [7:0]      leds
);

  if (CLK_HZ == 0) begin : g_clk_hz_check
    $error("custom_leds_ctrl: CLK_HZ must be nonzero");
  end

  logic [3:0]  r_ctrl;
  logic [7:0]  r_value;
  logic [31:0] r_period;
  logic [31:0] r_steps;
  logic [31:0] r_readdata;
  logic [7:0]  r_leds;
  src_e        r_src;
  logic [7:0]  r_pattern;
  logic [31:0] r_presc;
  logic        r_dir;
  state_e      r_state;
  logic [3:0]  r_dipsw_meta;
  logic [3:0]  r_dipsw_sync;

  state_e      w_state_next;
  mode_e       w_mode;
  logic        w_active, w_next_active, w_cfg_wr, w_load, w_run, w_step;
  logic        w_wr_ctrl, w_wr_value, w_wr_period, w_wr_steps;
  logic [3:0]  w_ctrl_next;
  logic [31:0] w_period_last, w_rd_mux;
  logic [7:0]  w_leds_next;
  src_e        w_src_next;
  logic [1:0]  w_pressed;
  step_t       w_step_res;

  custom_leds_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb0 (
    .clk(clk), .reset_n(reset_n), .button_n(button_n[0]), .pressed(w_pressed[0])
  );
  custom_leds_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb1 (
    .clk(clk), .reset_n(reset_n), .button_n(button_n[1]), .pressed(w_pressed[1])
  );

  assign w_wr_ctrl   = avs.avs_write && (avs.avs_address == ADDR_CTRL);
  assign w_wr_value  = avs.avs_write && (avs.avs_address == ADDR_VALUE);
  assign w_wr_period = avs.avs_write && (avs.avs_address == ADDR_PERIOD);
  assign w_wr_steps  = avs.avs_write && (avs.avs_address == ADDR_STEPS);
  assign w_cfg_wr    = w_wr_ctrl || w_wr_value || w_wr_period;

  assign w_mode        = mode_e'(r_ctrl[CTRL_MODE_LSB +: 2]);
  assign w_active      = r_ctrl[CTRL_EN_BIT] && (w_mode != MODE_STATIC);
  // CTRL as it will be after this cycle's write, so a disabling write does not restart.
  assign w_ctrl_next   = w_wr_ctrl ? avs.avs_writedata[3:0] : r_ctrl;
  assign w_next_active = w_ctrl_next[CTRL_EN_BIT] &&
                         (w_ctrl_next[CTRL_MODE_LSB +: 2] != MODE_STATIC);

  // PERIOD of 0 behaves as 1: terminal count is then 0.
  assign w_period_last = (r_period == 32'd0) ? 32'd0 : (r_period - 32'd1);
  assign w_step        = w_run && w_active && (r_presc >= w_period_last);
  assign w_step_res    = seq_step(w_mode, r_pattern, r_dir);

  assign avs.avs_readdata = r_readdata;
  assign leds             = r_leds;

  // Sequencer state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Sequencer next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_active) w_state_next = ST_LOAD;
        else          w_state_next = ST_IDLE;
      end
      ST_LOAD: begin
        if (w_cfg_wr && w_next_active) w_state_next = ST_LOAD;
        else                           w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!w_active)                      w_state_next = ST_IDLE;
        else if (w_cfg_wr && w_next_active) w_state_next = ST_LOAD;
        else                                w_state_next = ST_RUN;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Sequencer state decode into datapath controls.
  always_comb begin
    w_load = 1'b0;
    w_run  = 1'b0;
    case (r_state)
      ST_LOAD: w_load = 1'b1;
      ST_RUN:  w_run  = 1'b1;
      default: begin
        w_load = 1'b0;
        w_run  = 1'b0;
      end
    endcase
  end

  // Pattern, direction and prescaler; the pattern holds when the FSM idles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pattern <= 8'd0;
      r_presc   <= 32'd0;
      r_dir     <= DIR_LEFT;
    end else if (w_load) begin
      r_pattern <= r_value;
      r_presc   <= 32'd0;
      r_dir     <= DIR_LEFT;
    end else if (w_step) begin
      r_pattern <= w_step_res.pattern;
      r_dir     <= w_step_res.dir;
      r_presc   <= 32'd0;
    end else if (w_run && w_active) begin
      r_presc <= r_presc + 32'd1;
    end
  end

  // Writable configuration registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl   <= 4'd0;
      r_value  <= 8'd0;
      r_period <= 32'(DEFAULT_PERIOD);
    end else begin
      if (w_wr_ctrl)   r_ctrl   <= avs.avs_writedata[3:0];
      if (w_wr_value)  r_value  <= avs.avs_writedata[7:0];
      if (w_wr_period) r_period <= avs.avs_writedata;
    end
  end

  // Step counter; a write clears it and beats a coincident step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_steps <= 32'd0;
    end else if (w_wr_steps) begin
      r_steps <= 32'd0;
    end else if (w_step) begin
      r_steps <= r_steps + 32'd1;
    end
  end

  // Read mux over the current (pre-write) register contents.
  always_comb begin
    w_rd_mux = 32'd0;
    case (avs.avs_address)
      ADDR_CTRL:   w_rd_mux = {28'd0, r_ctrl};
      ADDR_VALUE:  w_rd_mux = {24'd0, r_value};
      ADDR_PERIOD: w_rd_mux = r_period;
      ADDR_STATUS: w_rd_mux = {19'd0, r_state, r_dir, r_src, r_leds};
      ADDR_STEPS:  w_rd_mux = r_steps;
      default:     w_rd_mux = 32'd0;
    endcase
  end

  // Read data register; holds between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= 32'd0;
    end else if (avs.avs_read) begin
      r_readdata <= w_rd_mux;
    end
  end

  // DIP switches need only a 2-FF synchronizer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dipsw_meta <= 4'd0;
      r_dipsw_sync <= 4'd0;
    end else begin
      r_dipsw_meta <= dipsw;
      r_dipsw_sync <= r_dipsw_meta;
    end
  end

  // Output arbiter: lamp test, DIP mirror, sequencer, static value.
  always_comb begin
    w_leds_next = r_value;
    w_src_next  = SRC_STATIC;
    if (r_ctrl[CTRL_OVR_BIT] && w_pressed[1]) begin
      w_leds_next = 8'hFF;
      w_src_next  = SRC_BUTTON;
    end else if (r_ctrl[CTRL_OVR_BIT] && w_pressed[0]) begin
      w_leds_next = {r_dipsw_sync, r_dipsw_sync};
      w_src_next  = SRC_BUTTON;
    end else if (w_active) begin
      w_leds_next = r_pattern;
      w_src_next  = SRC_SEQ;
    end else begin
      w_leds_next = r_value;
      w_src_next  = SRC_STATIC;
    end
  end

  // Registered LED drive and its source tag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_leds <= 8'd0;
      r_src  <= SRC_STATIC;
    end else begin
      r_leds <= w_leds_next;
      r_src  <= w_src_next;
    end
  end

endmodule

// File: doc/custom_leds_ctrl.md
# custom_leds_ctrl

Avalon-MM–controlled sequencer and arbiter for the 8-bit custom LED bank in `soc_system`. It sits between the HPS lightweight bridge and the LED pins, next to the button and DIP-switch PIO inputs. It decides each cycle which source drives the LEDs: a debounced board-button override, a hardware pattern sequencer (blink/rotate/bounce), or a static HPS-written value.

## Interface
- `CLK_HZ`, 50_000_000: clock frequency; documentation only.
- `DEFAULT_PERIOD`, 12_500_000: reset value of PERIOD, in clk cycles.
- `DEBOUNCE_CYCLES`, 500_000: number of cycles a button must be stable before its change is accepted.
- `clk`  in  1: single clock for all logic.
- `reset_n`  in  1: asynchronous, active-low reset.
- `avs_address`  in  3: word address of the register.
- `avs_read`, `avs_write`  in  1: Avalon strobes. There is no waitrequest.
- `avs_writedata`  in  32: write data.
- `avs_readdata`  out  32: read data, fixed read latency of 1 cycle.
- `button_n`  in  2: board buttons, active-low, asynchronous.
- `dipsw`  in  4: DIP switches, asynchronous.
- `leds`  out  8: registered LED drive.

## Operation
- Registers:
  - 0 CTRL (RW): [0] EN, [2:1] MODE (0 STATIC, 1 BLINK, 2 ROTATE, 3 BOUNCE), [3] HW_OVR_EN.
  - 1 VALUE (RW): [7:0] static pattern, also the sequencer seed.
  - 2 PERIOD (RW): [31:0] step interval in cycles. A value of 0 is treated as 1.
  - 3 STATUS (RO): [7:0] current leds, [9:8] SRC (0 static, 1 sequencer, 2 button), [10] DIR (0 left, 1 right), [12:11] FSM state.
  - 4 STEPS (RW): 32-bit count of sequencer steps, wraps. Any write clears it to 0.
- Unmapped addresses read as 0; writes to them are ignored.
- Arbitration priority, highest first:
  - HW_OVR_EN with debounced button1 pressed: leds = 0xFF (lamp test).
  - HW_OVR_EN with button0 pressed: leds = {dipsw_sync, dipsw_sync}.
  - EN with MODE≠STATIC: leds = sequencer pattern.
  - Otherwise: leds = VALUE[7:0].
- Button override only masks the output. The sequencer keeps running underneath.
- Sequencer FSM:
  - IDLE → LOAD when EN is set and MODE≠STATIC.
  - LOAD (one cycle): pattern←VALUE, prescaler←0, DIR←left, then go to RUN.
  - RUN: the prescaler counts 0..max(PERIOD,1)−1. On terminal count it takes one step and increments STEPS.
  - RUN → LOAD on any write to CTRL, VALUE or PERIOD while EN=1 and MODE≠STATIC.
  - RUN → IDLE when EN=0 or MODE=STATIC. The pattern register holds its value.
- Steps:
  - BLINK: pattern←~pattern.
  - ROTATE: rotate left by 1.
  - BOUNCE: shift in the DIR direction with zero fill. Before shifting, if the edge bit in the travel direction (bit7 going left, bit0 going right) is set, toggle DIR and shift the other way.
  - VALUE=0 stays 0 in every mode. 0xFF in BOUNCE stays 0xFF, with DIR toggling on every step.
- Simultaneous events:
  - Read and write to the same register in one cycle: readdata returns the pre-write value.
  - STEPS write and a step in the same cycle: the clear wins, STEPS=0.

## Timing
- Reset values: leds=0, avs_readdata=0, CTRL=0, VALUE=0, PERIOD=DEFAULT_PERIOD, STEPS=0, DIR=left, FSM=IDLE, debouncers released (not pressed).
- Read: avs_readdata is valid on the edge after the avs_read cycle and holds until the next read.
- Static write: VALUE is captured at edge N; leds shows it at edge N+1.
- Sequencer start: EN write captured at edge N gives LOAD at N+1 and RUN at N+2. The first step happens PERIOD cycles after entering RUN. leds reflects each step 1 cycle later.
- Buttons:
  - Path: 2-FF synchronizer, then the debouncer, then the arbiter.
  - The override asserts 2 + DEBOUNCE_CYCLES + 1 cycles after a stable press and releases with the same latency.
  - dipsw uses a 2-FF synchronizer only.
- Reset mid-operation: all state returns to reset values immediately (asynchronous assertion). Reset deassertion is synchronised externally.

## Structure
- `custom_leds_pkg`: the mode enum, the source enum, the FSM state enum, register address constants and CTRL bit positions.
- Sub-module `custom_leds_debounce`: a 2-FF synchronizer plus a stable counter of DEBOUNCE_CYCLES, producing an active-high `pressed` output. It is instantiated once per button.
- The top level contains the register file, the FSM with prescaler and pattern logic, and the output arbiter.

## Test plan
- Static display: reset, write VALUE=0xA5, CTRL=0x1 → leds=0xA5 one cycle after the VALUE write, and STATUS.SRC=0.
- ROTATE: VALUE=0x01, PERIOD=4, CTRL=0x5 → leds steps 0x01,0x02,0x04…0x80,0x01 every 4 cycles; STEPS=9 after 9 steps.
- BOUNCE at the edges: VALUE=0x40, PERIOD=1, CTRL=0x7 → leds 0x40,0x80,0x40,0x20 with DIR toggling at 0x80. PERIOD=0 behaves identically.
- Button override: DEBOUNCE_CYCLES=8, HW_OVR_EN=1, dipsw=0x3, press button0 → leds=0x33 after 11 cycles. A 5-cycle glitch has no effect. Pressing button1 as well → 0xFF.
- Restart and clear: while RUN, write PERIOD → FSM passes through LOAD and the pattern reloads VALUE. A STEPS write that coincides with a step reads back 0.
- Async reset mid-RUN → leds=0, CTRL=0, PERIOD=DEFAULT_PERIOD, FSM=IDLE, all in the same cycle.
